// File: rtl/i2c_target_regs.sv
// I2C target with a NUM_REGS x 8 register bank and an auto-incrementing pointer.
// SCL/SDA are synchronised and debounced on clk. START/STOP are decoded from the
// filtered lines, and bus writes are mirrored to the local side as one-clk strobes.
module i2c_target_regs #(
    parameter logic [6:0]  DEV_ADDR   = 7'h42,
    parameter int unsigned NUM_REGS   = 16,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] loc_rd_addr,
    output logic [7:0] loc_rd_data,
    output logic       wr_pulse,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam int unsigned PW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned FW  = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [8:0]  NR9 = 9'(NUM_REGS);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_PTR, S_WDATA, S_RDATA, S_IGNORE
    } state_t;

    // ACK slot tracking: armed after the 8th rise, driving after the next fall.
    typedef enum logic [1:0] {
        AK_NONE, AK_ARMED, AK_DRIVE
    } ack_t;

    logic [1:0]    r_scl_s, r_sda_s;
    logic [FW-1:0] r_scl_cnt, r_sda_cnt;
    logic          r_scl_f, r_sda_f, r_scl_fd, r_sda_fd;

    state_t        r_state;
    ack_t          r_ack_st;
    logic [3:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic [PW-1:0] r_ptr;
    logic [7:0]    r_bank [NUM_REGS];

    logic          w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [7:0]    w_byte;
    logic [7:0]    w_load;
    logic [PW-1:0] w_ptr_next;

    assign w_scl_rise = r_scl_f & ~r_scl_fd;
    assign w_scl_fall = ~r_scl_f & r_scl_fd;
    assign w_start    = r_scl_f & r_scl_fd & r_sda_fd & ~r_sda_f;
    assign w_stop     = r_scl_f & r_scl_fd & ~r_sda_fd & r_sda_f;
    assign w_byte     = {r_shift[6:0], r_sda_f};
    assign w_load     = r_bank[r_ptr];
    assign w_ptr_next = (r_ptr == PW'(NUM_REGS - 1)) ? '0 : r_ptr + 1'b1;

    assign loc_rd_data = ({1'b0, loc_rd_addr} < NR9) ? r_bank[loc_rd_addr[PW-1:0]] : 8'h00;

    // Synchronise the pads, debounce each line, and keep the previous filtered level
    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_scl_s   <= 2'b11;
            r_sda_s   <= 2'b11;
            r_scl_cnt <= '0;
            r_sda_cnt <= '0;
            r_scl_f   <= 1'b1;
            r_sda_f   <= 1'b1;
            r_scl_fd  <= 1'b1;
            r_sda_fd  <= 1'b1;
        end else begin
            r_scl_s  <= {r_scl_s[0], scl_in};
            r_sda_s  <= {r_sda_s[0], sda_in};
            r_scl_fd <= r_scl_f;
            r_sda_fd <= r_sda_f;

            if (r_scl_s[1] == r_scl_f) begin
                r_scl_cnt <= '0;
            end else if (r_scl_cnt == FW'(FILTER_LEN - 1)) begin
                r_scl_f   <= r_scl_s[1];
                r_scl_cnt <= '0;
            end else begin
                r_scl_cnt <= r_scl_cnt + 1'b1;
            end

            if (r_sda_s[1] == r_sda_f) begin
                r_sda_cnt <= '0;
            end else if (r_sda_cnt == FW'(FILTER_LEN - 1)) begin
                r_sda_f   <= r_sda_s[1];
                r_sda_cnt <= '0;
            end else begin
                r_sda_cnt <= r_sda_cnt + 1'b1;
            end
        end
    end

    // Protocol FSM: byte reception, ACK slots, read shifting and the register bank
    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state  <= S_IDLE;
            r_ack_st <= AK_NONE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_ptr    <= '0;
            sda_oe   <= 1'b0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            wr_pulse <= 1'b0;
            if (w_stop) begin
                r_state  <= S_IDLE;
                r_ack_st <= AK_NONE;
                r_bitcnt <= '0;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
            end else if (w_start) begin
                r_state  <= S_ADDR;
                r_ack_st <= AK_NONE;
                r_bitcnt <= '0;
                sda_oe   <= 1'b0;
            end else if (r_ack_st == AK_ARMED) begin
                if (w_scl_fall) begin
                    sda_oe   <= 1'b1;
                    r_ack_st <= AK_DRIVE;
                end
            end else if (r_ack_st == AK_DRIVE) begin
                // The fall ending our ACK either releases SDA or starts a read byte.
                if (w_scl_fall) begin
                    r_ack_st <= AK_NONE;
                    r_bitcnt <= '0;
                    if (r_state == S_RDATA) begin
                        r_shift <= w_load;
                        sda_oe  <= ~w_load[7];
                        r_ptr   <= w_ptr_next;
                    end else begin
                        sda_oe  <= 1'b0;
                    end
                end
            end else begin
                case (r_state)
                    S_ADDR, S_PTR, S_WDATA: begin
                        if (w_scl_rise) begin
                            r_shift  <= w_byte;
                            r_bitcnt <= r_bitcnt + 1'b1;
                            if (r_bitcnt == 4'd7) begin
                                case (r_state)
                                    S_ADDR: begin
                                        if (w_byte[7:1] == DEV_ADDR) begin
                                            busy     <= 1'b1;
                                            r_ack_st <= AK_ARMED;
                                            r_state  <= w_byte[0] ? S_RDATA : S_PTR;
                                        end else begin
                                            r_state  <= S_IGNORE;
                                        end
                                    end
                                    S_PTR: begin
                                        if ({1'b0, w_byte} < NR9) begin
                                            r_ptr    <= w_byte[PW-1:0];
                                            r_ack_st <= AK_ARMED;
                                            r_state  <= S_WDATA;
                                        end else begin
                                            r_state  <= S_IGNORE;
                                        end
                                    end
                                    default: begin
                                        r_bank[r_ptr] <= w_byte;
                                        wr_pulse      <= 1'b1;
                                        wr_addr       <= 8'(r_ptr);
                                        wr_data       <= w_byte;
                                        r_ptr         <= w_ptr_next;
                                        r_ack_st      <= AK_ARMED;
                                    end
                                endcase
                            end
                        end
                    end
                    S_RDATA: begin
                        // r_bitcnt counts master rises: 1..7 shift, 8 release, 9 reload.
                        if (w_scl_rise) begin
                            if (r_bitcnt < 4'd8) begin
                                r_bitcnt <= r_bitcnt + 1'b1;
                            end else if (r_bitcnt == 4'd8) begin
                                if (!r_sda_f) begin
                                    r_bitcnt <= 4'd9;
                                end else begin
                                    r_state  <= S_IGNORE;
                                    r_bitcnt <= '0;
                                end
                            end
                        end else if (w_scl_fall) begin
                            if (r_bitcnt >= 4'd1 && r_bitcnt <= 4'd7) begin
                                r_shift <= {r_shift[6:0], 1'b0};
                                sda_oe  <= ~r_shift[6];
                            end else if (r_bitcnt == 4'd8) begin
                                sda_oe  <= 1'b0;
                            end else if (r_bitcnt == 4'd9) begin
                                r_shift  <= w_load;
                                sda_oe   <= ~w_load[7];
                                r_ptr    <= w_ptr_next;
                                r_bitcnt <= '0;
                            end
                        end
                    end
                    S_IGNORE: sda_oe <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C master drives the DUT, a register-file
// model predicts ACKs, read bytes and write strobes, and monitor processes compare.
module tb_i2c_target_regs;

    localparam logic [6:0] DEV = 7'h42;
    localparam int         NR  = 16;
    localparam int         Q   = 8;      // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       nReset = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       glitch = 1'b0;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] loc_rd_addr = 8'h00;
    logic [7:0] loc_rd_data;
    logic       wr_pulse;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    assign sda_in = (m_sda & ~sda_oe) ^ glitch;

    i2c_target_regs #(
        .DEV_ADDR   (DEV),
        .NUM_REGS   (NR),
        .FILTER_LEN (3)
    ) dut (
        .clk         (clk),
        .nReset      (nReset),
        .scl_in      (m_scl),
        .sda_in      (sda_in),
        .sda_oe      (sda_oe),
        .loc_rd_addr (loc_rd_addr),
        .loc_rd_data (loc_rd_data),
        .wr_pulse    (wr_pulse),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          glitch_en = 1'b0;
    logic [7:0]  model_bank [NR];
    int          model_ptr = 0;
    logic [15:0] exp_wr [$];   // {addr, data}
    logic [15:0] exp_rsp [$];  // {tag, value}: tag 1 = target ACK, tag 2 = read byte
    logic [15:0] obs_rsp [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_q();
        m_scl = 1'b1; wait_q();
        m_sda = 1'b1; wait_q();
    endtask

    task automatic wr_bit(input logic b, input bit ge);
        m_sda = b; wait_q();
        m_scl = 1'b1;
        if (ge) begin
            repeat (3) @(negedge clk);
            glitch = 1'b1;
            repeat (2) @(negedge clk);
            glitch = 1'b0;
            repeat (2 * Q - 5) @(negedge clk);
        end else begin
            repeat (2 * Q) @(negedge clk);
        end
        m_scl = 1'b0; wait_q();
    endtask

    task automatic send_bits(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) wr_bit(v[i], glitch_en);
    endtask

    task automatic send_byte(input logic [7:0] v);
        bit a;
        send_bits(v);
        m_sda = 1'b1; wait_q();
        m_scl = 1'b1; wait_q();
        a = (sda_in == 1'b0);
        wait_q();
        m_scl = 1'b0; wait_q();
        obs_rsp.push_back({8'h01, 7'b0, a});
    endtask

    task automatic read_byte(input bit mack);
        logic [7:0] v;
        for (int i = 7; i >= 0; i--) begin
            m_sda = 1'b1; wait_q();
            m_scl = 1'b1; wait_q();
            v[i] = sda_in;
            wait_q();
            m_scl = 1'b0; wait_q();
        end
        obs_rsp.push_back({8'h02, v});
        m_sda = mack ? 1'b0 : 1'b1; wait_q();
        m_scl = 1'b1; wait_q(); wait_q();
        m_scl = 1'b0; wait_q();
    endtask

    task automatic exp_ack(input bit a);
        exp_rsp.push_back({8'h01, 7'b0, a});
    endtask

    task automatic after_stop_checks();
        chk("busy_after_stop", busy, 0);
        chk("oe_after_stop", sda_oe, 0);
    endtask

    // Model: address match, pointer range check, bank update with modulo pointer.
    task automatic do_write(input logic [6:0] a7, input logic [7:0] p, input int n,
                            input logic [7:0] d [4]);
        i2c_start();
        exp_ack(a7 == DEV);
        send_byte({a7, 1'b0});
        chk("busy_after_addr", busy, (a7 == DEV));
        if (a7 == DEV) begin
            exp_ack(int'(p) < NR);
            send_byte(p);
            if (int'(p) < NR) begin
                model_ptr = int'(p);
                for (int i = 0; i < n; i++) begin
                    exp_ack(1'b1);
                    exp_wr.push_back({8'(model_ptr), d[i]});
                    model_bank[model_ptr] = d[i];
                    model_ptr = (model_ptr + 1) % NR;
                    send_byte(d[i]);
                end
            end
        end
        i2c_stop();
        after_stop_checks();
    endtask

    task automatic do_read(input bit set_ptr, input logic [7:0] p, input int n);
        bit go;
        go = 1'b1;
        i2c_start();
        if (set_ptr) begin
            exp_ack(1'b1);
            send_byte({DEV, 1'b0});
            exp_ack(int'(p) < NR);
            send_byte(p);
            if (int'(p) < NR) begin
                model_ptr = int'(p);
                i2c_start();
            end else begin
                go = 1'b0;
            end
        end
        if (go) begin
            exp_ack(1'b1);
            send_byte({DEV, 1'b1});
            for (int i = 0; i < n; i++) begin
                exp_rsp.push_back({8'h02, model_bank[model_ptr]});
                model_ptr = (model_ptr + 1) % NR;
                read_byte(i != n - 1);
            end
            chk("oe_after_nack", sda_oe, 0);
        end
        i2c_stop();
        after_stop_checks();
    endtask

    task automatic check_bank();
        for (int i = 0; i < NR; i++) begin
            loc_rd_addr = 8'(i);
            #1;
            chk($sformatf("bank[%0d]", i), loc_rd_data, model_bank[i]);
        end
        loc_rd_addr = 8'(NR + $urandom_range(0, 255 - NR));
        #1;
        chk("bank_oob", loc_rd_data, 0);
        @(negedge clk);
    endtask

    // Write-strobe monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (nReset && wr_pulse) begin
                if (exp_wr.size() == 0) begin
                    chk("wr_unexpected", {wr_addr, wr_data}, 16'hxxxx);
                end else begin
                    chk("wr_strobe", {wr_addr, wr_data}, exp_wr.pop_front());
                end
            end
        end
    end

    // Bus response monitor (ACK bits and read bytes)
    initial begin
        forever begin
            @(negedge clk);
            while (obs_rsp.size() > 0) begin
                logic [15:0] o;
                o = obs_rsp.pop_front();
                if (exp_rsp.size() == 0) begin
                    chk("rsp_unexpected", o, 16'hxxxx);
                end else begin
                    chk((o[15:8] == 8'h01) ? "target_ack" : "read_data", o, exp_rsp.pop_front());
                end
            end
        end
    end

    // Watchdog
    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: cycle budget expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d [4];
        logic [6:0] a7;
        for (int i = 0; i < NR; i++) model_bank[i] = 8'h00;

        repeat (4) @(negedge clk);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        nReset = 1'b1;
        repeat (10) @(negedge clk);
        check_bank();

        // Write 0xAA, 0x55 from pointer 3
        d = '{8'hAA, 8'h55, 8'h00, 8'h00};
        do_write(DEV, 8'h03, 2, d);
        check_bank();

        // Pointer 3, repeated START, read two bytes
        do_read(1'b1, 8'h03, 2);

        // Foreign address is ignored, then a normal write is accepted
        d = '{8'h77, 8'h00, 8'h00, 8'h00};
        do_write(7'h48, 8'h05, 1, d);
        check_bank();
        do_write(DEV, 8'h05, 1, d);

        // Pointer wrap on write, out-of-range pointer rejected
        d = '{8'h11, 8'h22, 8'h00, 8'h00};
        do_write(DEV, 8'h0F, 2, d);
        d = '{8'h99, 8'h00, 8'h00, 8'h00};
        do_write(DEV, 8'h10, 1, d);
        check_bank();
        do_read(1'b1, 8'h0F, 3);

        // Reset asserted while the target drives the address ACK
        i2c_start();
        send_bits({DEV, 1'b0});
        m_sda = 1'b1; wait_q();
        chk("ack_driven_before_reset", sda_oe, 1);
        chk("busy_before_reset", busy, 1);
        nReset = 1'b0;
        @(negedge clk);
        chk("oe_after_reset", sda_oe, 0);
        chk("busy_after_reset", busy, 0);
        chk("wr_addr_after_reset", wr_addr, 0);
        for (int i = 0; i < NR; i++) model_bank[i] = 8'h00;
        model_ptr = 0;
        check_bank();
        nReset = 1'b1;
        m_scl = 1'b1; wait_q(); wait_q();
        m_scl = 1'b0; wait_q();
        i2c_stop();
        d = '{8'h3C, 8'hC3, 8'h00, 8'h00};
        do_write(DEV, 8'h07, 2, d);
        check_bank();

        // 2-clk SDA glitches during every master bit must not restart or end the transfer
        glitch_en = 1'b1;
        d = '{8'h5A, 8'hFF, 8'h00, 8'h81};
        do_write(DEV, 8'h0A, 4, d);
        glitch_en = 1'b0;
        check_bank();

        // Randomised transactions against the model
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 1) == 1) begin
                a7 = ($urandom_range(0, 4) == 0) ? 7'($urandom) : DEV;
                for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
                do_write(a7, 8'($urandom_range(0, 18)), int'($urandom_range(0, 3)), d);
            end else begin
                do_read($urandom_range(0, 3) != 0, 8'($urandom_range(0, 17)),
                        int'($urandom_range(1, 3)));
            end
            check_bank();
        end

        repeat (20) @(negedge clk);
        chk("exp_wr_drained", exp_wr.size(), 0);
        chk("exp_rsp_drained", exp_rsp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
